i2c_config_sequencer: RTL and testbench

Walks a table of register writes and issues each one, in order, through the `I2CMaster` write engine. It owns the master's `enable`, `deviceID`, `register` and `din` inputs. It retries NACKed or timed-out transfers, inserts a settle gap between writes, and reports done or fail with the failing table index. It sits between the power-up and reset logic and the I2C master, and configures the external codec or decoder before the scope datapath is released.

---
 rtl/i2c_config_sequencer.sv | 146 ++++++++++++++
 tb/tb_i2c_config_sequencer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_config_sequencer.sv
// i2c_config_sequencer: walks a register-write table through the I2C master with retry, timeout and settle gap
module i2c_config_sequencer #(
    parameter logic [6:0] DEVICE_ID = 7'h1A,
    parameter int         NUM_REGS  = 10,
    parameter int         MAX_RETRY = 3,
    parameter int         TIMEOUT   = 200000,
    parameter int         GAP       = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [6:0]  tbl_addr,
    input  logic [15:0] tbl_data,
    output logic [6:0]  i2c_device,
    output logic [6:0]  i2c_register,
    output logic [8:0]  i2c_din,
    output logic        i2c_enable,
    input  logic        i2c_rdy,
    input  logic        i2c_err,
    input  logic [3:0]  i2c_stt,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [6:0]  fail_index
);
    localparam int              TW     = $clog2(TIMEOUT + 1);
    localparam int              GW     = $clog2(GAP + 1);
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0]   G_LAST = GW'(GAP - 1);
    localparam logic [3:0]      R_MAX  = 4'(MAX_RETRY);
    localparam logic [6:0]      I_LAST = 7'(NUM_REGS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_ACCEPT, S_WAIT, S_CHECK, S_GAP, S_DONE, S_FAIL
    } state_t;

    state_t          state, state_n;
    logic [1:0]      rdy_s, err_s, stt_s;
    logic            rdy_prev, tout, at_end;
    logic [TW-1:0]   tcnt;
    logic [GW-1:0]   gcnt;
    logic [3:0]      retry;
    logic            rdy_edge, t_hit, xfer_err, fetch_end;

    assign i2c_device = DEVICE_ID;
    assign rdy_edge   = rdy_s[1] & ~rdy_prev;
    // tcnt is 1 in the first ACCEPT cycle, so CHECK lands exactly TIMEOUT cycles after ISSUE
    assign t_hit      = tcnt == T_LAST;
    assign xfer_err   = err_s[1] | tout;
    // at_end stands in for tbl_addr == NUM_REGS, which a 7-bit index cannot hold when NUM_REGS is 128
    assign fetch_end  = (tbl_data[15:9] == 7'h7F) || at_end;

    // Two-flop synchronizers for the master's handshake signals
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdy_s <= '0;
            err_s <= '0;
            stt_s <= '0;
        end else begin
            rdy_s <= {rdy_s[0], i2c_rdy};
            err_s <= {err_s[0], i2c_err};
            stt_s <= {stt_s[0], |i2c_stt};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:         state_n = start ? S_FETCH : S_IDLE;
            S_FETCH:        state_n = fetch_end ? S_DONE : S_ISSUE;
            S_ISSUE:        state_n = S_ACCEPT;
            S_ACCEPT:       state_n = t_hit ? S_CHECK : stt_s[1] ? S_WAIT : S_ACCEPT;
            S_WAIT:         state_n = (t_hit || rdy_edge) ? S_CHECK : S_WAIT;
            S_CHECK:        state_n = (!xfer_err || retry < R_MAX) ? S_GAP : S_FAIL;
            S_GAP:          state_n = (gcnt == G_LAST) ? S_FETCH : S_GAP;
            S_DONE, S_FAIL: state_n = start ? state : S_IDLE;
            default:        state_n = S_IDLE;
        endcase
    end

    // Datapath: table index, latched write, handshake, counters and sticky status
    always_ff @(posedge clk) begin
        if (!reset) begin
            tbl_addr     <= '0;
            i2c_register <= '0;
            i2c_din      <= '0;
            i2c_enable   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fail         <= 1'b0;
            fail_index   <= '0;
            rdy_prev     <= 1'b0;
            tout         <= 1'b0;
            at_end       <= 1'b0;
            tcnt         <= '0;
            gcnt         <= '0;
            retry        <= '0;
        end else begin
            i2c_enable <= state_n == S_ACCEPT;
            busy       <= !(state_n inside {S_IDLE, S_DONE, S_FAIL});
            rdy_prev   <= (state == S_ISSUE) ? 1'b0 : rdy_s[1];
            gcnt       <= (state == S_GAP) ? gcnt + 1'b1 : '0;
            if (state == S_ISSUE) begin
                tcnt <= TW'(1);
                tout <= 1'b0;
            end else if (state inside {S_ACCEPT, S_WAIT}) begin
                tcnt <= tcnt + 1'b1;
                if (t_hit) tout <= 1'b1;
            end
            if (state == S_IDLE && start) begin
                tbl_addr <= '0;
                retry    <= '0;
                at_end   <= 1'b0;
                done     <= 1'b0;
                fail     <= 1'b0;
            end
            if (state == S_FETCH) begin
                if (fetch_end) begin
                    done <= 1'b1;
                end else begin
                    i2c_register <= tbl_data[15:9];
                    i2c_din      <= tbl_data[8:0];
                end
            end
            if (state == S_CHECK) begin
                if (!xfer_err) begin
                    tbl_addr <= (tbl_addr == 7'h7F) ? tbl_addr : tbl_addr + 7'd1;
                    at_end   <= tbl_addr == I_LAST;
                    retry    <= '0;
                end else if (retry < R_MAX) begin
                    retry <= retry + 4'd1;
                end else begin
                    fail       <= 1'b1;
                    fail_index <= tbl_addr;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_config_sequencer.sv
// tb_i2c_config_sequencer: randomized and directed checks of the config sequencer against a table-walk reference model
module tb_i2c_config_sequencer;
    localparam int NR = 3;
    localparam int MR = 2;
    localparam int TO = 500;
    localparam int GP = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  tbl_addr;
    logic [15:0] tbl_data;
    logic [6:0]  i2c_device, i2c_register, fail_index;
    logic [8:0]  i2c_din;
    logic        i2c_enable, busy, done, fail;
    logic        i2c_rdy, i2c_err;
    logic [3:0]  i2c_stt;

    logic [15:0] tbl [0:127];
    int          plan_q[$], plan_ref[$];
    logic [15:0] obs_q[$], exp_q[$];
    int          en_cyc_q[$], fall_q[$];
    int          cyc = 0, stt_cyc = 0, fail_cyc = 0, lat_ovr = -1, start_cyc = 0;
    logic        en_d = 1'b0, fail_d = 1'b0;
    int          vectors = 0, errors = 0;
    bit          exp_done, seq_timeout;
    int          exp_idx, exp_addr;

    i2c_config_sequencer #(.NUM_REGS(NR), .MAX_RETRY(MR), .TIMEOUT(TO), .GAP(GP)) dut (
        .clk(clk), .reset(reset), .start(start), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .i2c_device(i2c_device), .i2c_register(i2c_register), .i2c_din(i2c_din),
        .i2c_enable(i2c_enable), .i2c_rdy(i2c_rdy), .i2c_err(i2c_err), .i2c_stt(i2c_stt),
        .busy(busy), .done(done), .fail(fail), .fail_index(fail_index)
    );

    assign tbl_data = tbl[tbl_addr];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Master model: responses come from plan_q (0 ack, 1 nack, 2 SCL held low forever)
    initial begin : master
        int resp, lat, dur;
        i2c_rdy = 1'b1;
        i2c_err = 1'b0;
        i2c_stt = 4'd0;
        forever begin
            @(negedge clk);
            if (reset && i2c_enable) begin
                resp = (plan_q.size() > 0) ? plan_q.pop_front() : 0;
                lat  = (lat_ovr >= 0) ? lat_ovr : int'($urandom_range(0, 3));
                dur  = int'($urandom_range(5, 20));
                for (int k = 0; k < lat && reset; k++) @(negedge clk);
                if (reset) begin
                    i2c_stt = 4'($urandom_range(1, 15));
                    i2c_rdy = 1'b0;
                    i2c_err = 1'b0;
                    stt_cyc = cyc;
                end
                if (resp == 2) while (reset) @(negedge clk);
                else for (int k = 0; k < dur && reset; k++) @(negedge clk);
                i2c_stt = 4'd0;
                i2c_rdy = 1'b1;
                i2c_err = reset && resp == 1;
                while (reset && i2c_enable) @(negedge clk);
            end
        end
    end

    // Monitor: logs each enable rise, the enable-fall latency after stt, and the fail rise cycle
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (i2c_enable && !en_d) begin
                obs_q.push_back({i2c_register, i2c_din});
                en_cyc_q.push_back(cyc);
            end
            if (!i2c_enable && en_d && reset) fall_q.push_back(cyc - stt_cyc);
            if (fail && !fail_d) fail_cyc = cyc;
            en_d   = i2c_enable;
            fail_d = fail;
        end
    end

    // Reference: walk the table, consuming one planned response per transfer
    task automatic ref_model();
        int i = 0, a = 0, p = 0, r;
        exp_q.delete();
        exp_done = 1'b0;
        exp_idx  = 0;
        for (int g = 0; g < 1000; g++) begin
            if (i == NR || tbl[i][15:9] == 7'h7F) begin
                exp_done = 1'b1;
                break;
            end
            exp_q.push_back(tbl[i]);
            r = (p < plan_ref.size()) ? plan_ref[p] : 0;
            p++;
            if (r == 0) begin
                i++;
                a = 0;
            end else if (a < MR) begin
                a++;
            end else begin
                exp_idx = i;
                break;
            end
        end
        exp_addr = i;
    endtask

    task automatic run_seq(input int budget);
        ref_model();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        plan_q = plan_ref;
        obs_q.delete();
        en_cyc_q.delete();
        fall_q.delete();
        fail_cyc = 0;
        reset = 1'b1;
        @(negedge clk);
        start = 1'b1;
        start_cyc = cyc;
        seq_timeout = 1'b1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done || fail) begin
                seq_timeout = 1'b0;
                break;
            end
        end
    endtask

    function automatic int first_diff();
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    function automatic int bad_falls();
        int n = 0;
        foreach (fall_q[i]) if (fall_q[i] != 3) n++;
        return n;
    endfunction

    function automatic int min_gap();
        int m = 1 << 30;
        for (int i = 1; i < en_cyc_q.size(); i++)
            if (en_cyc_q[i] - en_cyc_q[i-1] < m) m = en_cyc_q[i] - en_cyc_q[i-1];
        return m;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({tbl_addr, i2c_register, i2c_din} !== 23'd0) begin
            errors++;
            $display("FAIL reset_regs got %h %h %h want 0", tbl_addr, i2c_register, i2c_din);
        end
        vectors++;
        if ({i2c_enable, busy, done, fail, fail_index} !== 11'd0) begin
            errors++;
            $display("FAIL reset_flags got en=%b busy=%b done=%b fail=%b idx=%0d want 0", i2c_enable, busy, done, fail, fail_index);
        end
        vectors++;
        if (i2c_device !== 7'h1A) begin
            errors++;
            $display("FAIL device_id got %h want 1a", i2c_device);
        end
    endtask

    task automatic test_three_entry();
        tbl[0] = {7'h0F, 9'h000};
        tbl[1] = {7'h06, 9'h000};
        tbl[2] = {7'h09, 9'h001};
        tbl[3] = 16'h1234;
        plan_ref = {};
        run_seq(5000);
        vectors++;
        if (seq_timeout || obs_q.size() != 3 || first_diff() != -1) begin
            errors++;
            $display("FAIL three_xfers got n=%0d diff=%0d to=%0b want n=3 diff=-1", obs_q.size(), first_diff(), seq_timeout);
        end
        vectors++;
        if ({done, fail, busy, tbl_addr} !== {3'b100, 7'd3}) begin
            errors++;
            $display("FAIL three_status got done=%b fail=%b busy=%b addr=%0d want 1 0 0 3", done, fail, busy, tbl_addr);
        end
        vectors++;
        if (en_cyc_q[0] - start_cyc != 3) begin
            errors++;
            $display("FAIL start_latency got %0d want 3", en_cyc_q[0] - start_cyc);
        end
        vectors++;
        if (bad_falls() != 0 || fall_q.size() != 3) begin
            errors++;
            $display("FAIL enable_fall got bad=%0d n=%0d want bad=0 n=3", bad_falls(), fall_q.size());
        end
        vectors++;
        if (min_gap() < GP + 3) begin
            errors++;
            $display("FAIL enable_gap got %0d want >=%0d", min_gap(), GP + 3);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        repeat (30) @(negedge clk);
        vectors++;
        if (obs_q.size() != 3 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_held got n=%0d done=%b busy=%b want 3 1 0", obs_q.size(), done, busy);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_sticky got %b want 1", done);
        end
        start = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL restart got busy=%b done=%b want 1 0", busy, done);
        end
        n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (obs_q.size() != 6 || done !== 1'b1) begin
            errors++;
            $display("FAIL second_run got n=%0d done=%b want 6 1", obs_q.size(), done);
        end
    endtask

    task automatic test_end_marker();
        tbl[0] = {7'($urandom_range(0, 126)), 9'($urandom)};
        tbl[1] = 16'hFE00;
        plan_ref = {};
        run_seq(5000);
        vectors++;
        if (obs_q.size() != 1 || first_diff() != -1 || done !== 1'b1 || tbl_addr !== 7'd1) begin
            errors++;
            $display("FAIL end_marker got n=%0d diff=%0d done=%b addr=%0d want 1 -1 1 1", obs_q.size(), first_diff(), done, tbl_addr);
        end
    endtask

    task automatic test_single_nack();
        for (int i = 0; i < NR; i++) tbl[i] = {7'($urandom_range(0, 126)), 9'($urandom)};
        plan_ref = {1};
        run_seq(5000);
        vectors++;
        if (obs_q.size() != exp_q.size() || obs_q.size() != 4 || first_diff() != -1) begin
            errors++;
            $display("FAIL single_nack_xfers got n=%0d diff=%0d want n=4 diff=-1", obs_q.size(), first_diff());
        end
        vectors++;
        if (done !== 1'b1 || fail !== 1'b0) begin
            errors++;
            $display("FAIL single_nack_status got done=%b fail=%b want 1 0", done, fail);
        end
    endtask

    task automatic test_persistent_nack();
        for (int i = 0; i < NR; i++) tbl[i] = {7'($urandom_range(0, 126)), 9'($urandom)};
        plan_ref = {0, 1, 1, 1};
        run_seq(5000);
        vectors++;
        if (obs_q.size() != 4 || first_diff() != -1) begin
            errors++;
            $display("FAIL persist_xfers got n=%0d diff=%0d want n=4 diff=-1", obs_q.size(), first_diff());
        end
        vectors++;
        if ({done, fail, busy, fail_index} !== {3'b010, 7'd1}) begin
            errors++;
            $display("FAIL persist_status got done=%b fail=%b busy=%b idx=%0d want 0 1 0 1", done, fail, busy, fail_index);
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < NR; i++) tbl[i] = {7'($urandom_range(0, 126)), 9'($urandom)};
        plan_ref = {2, 2, 2};
        run_seq(5000);
        vectors++;
        if (obs_q.size() != MR + 1 || first_diff() != -1 || fail !== 1'b1 || fail_index !== 7'd0) begin
            errors++;
            $display("FAIL timeout_status got n=%0d diff=%0d fail=%b idx=%0d want 3 -1 1 0", obs_q.size(), first_diff(), fail, fail_index);
        end
        vectors++;
        if (en_cyc_q[1] - en_cyc_q[0] != TO + GP + 2 || en_cyc_q[2] - en_cyc_q[1] != TO + GP + 2) begin
            errors++;
            $display("FAIL timeout_retry_spacing got %0d %0d want %0d", en_cyc_q[1] - en_cyc_q[0], en_cyc_q[2] - en_cyc_q[1], TO + GP + 2);
        end
        vectors++;
        if (fail_cyc - en_cyc_q[2] != TO) begin
            errors++;
            $display("FAIL timeout_fail_time got %0d want %0d", fail_cyc - en_cyc_q[2], TO);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        for (int i = 0; i < NR; i++) tbl[i] = {7'($urandom_range(0, 126)), 9'($urandom)};
        plan_ref = {};
        run_seq(0);
        n = 0;
        while (fall_q.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (n >= 200 || i2c_enable !== 1'b0 || busy !== 1'b0 || tbl_addr !== 7'd0) begin
            errors++;
            $display("FAIL reset_in_wait got n=%0d en=%b busy=%b addr=%0d want en=0 busy=0 addr=0", n, i2c_enable, busy, tbl_addr);
        end
        reset = 1'b1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        vectors++;
        if (obs_q.size() != 1 || busy !== 1'b0 || i2c_enable !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got n=%0d busy=%b en=%b want 1 0 0", obs_q.size(), busy, i2c_enable);
        end
        lat_ovr = 8;
        run_seq(0);
        n = 0;
        while (!i2c_enable && n < 200) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b0;
        @(negedge clk);
        lat_ovr = -1;
        vectors++;
        if (n >= 200 || i2c_enable !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_accept got n=%0d en=%b busy=%b want en=0 busy=0", n, i2c_enable, busy);
        end
        run_seq(5000);
        vectors++;
        if (obs_q.size() != 3 || first_diff() != -1 || done !== 1'b1 || fail !== 1'b0) begin
            errors++;
            $display("FAIL clean_restart got n=%0d diff=%0d done=%b fail=%b want 3 -1 1 0", obs_q.size(), first_diff(), done, fail);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < NR; i++)
                tbl[i] = {($urandom_range(0, 5) == 0) ? 7'h7F : 7'($urandom_range(0, 126)), 9'($urandom)};
            plan_ref = {};
            for (int k = int'($urandom_range(0, 6)); k > 0; k--) plan_ref.push_back(($urandom_range(0, 2) == 0) ? 1 : 0);
            run_seq(8000);
            vectors++;
            if (seq_timeout || obs_q.size() != exp_q.size() || first_diff() != -1) begin
                errors++;
                $display("FAIL rand%0d_xfers got n=%0d diff=%0d to=%0b want n=%0d", it, obs_q.size(), first_diff(), seq_timeout, exp_q.size());
            end
            vectors++;
            if (done !== exp_done || fail !== !exp_done || tbl_addr !== 7'(exp_addr) || (!exp_done && fail_index !== 7'(exp_idx))) begin
                errors++;
                $display("FAIL rand%0d_status got done=%b fail=%b addr=%0d idx=%0d want %b %b %0d %0d", it, done, fail, tbl_addr, fail_index, exp_done, !exp_done, exp_addr, exp_idx);
            end
            vectors++;
            if (bad_falls() != 0 || min_gap() < GP + 3) begin
                errors++;
                $display("FAIL rand%0d_timing got bad_falls=%0d min_gap=%0d want 0 >=%0d", it, bad_falls(), min_gap(), GP + 3);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) tbl[i] = 16'h0000;
        test_reset();
        test_three_entry();
        test_back_to_back();
        test_end_marker();
        test_single_nack();
        test_persistent_nack();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
